// File: rtl/obs_split_feeder.sv
// Operand-side feeder for an OBS level: splits an N-bit GF(2) operand pair into even/odd
// coefficient halves and issues the four half-size sub-products as serial beats.
module obs_split_feeder #(
    parameter int N = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_a,
    input  logic [N-1:0]     in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N/2-1:0]   out_a,
    output logic [N/2-1:0]   out_b,
    output logic [1:0]       out_tag,
    output logic             out_last,
    output logic             busy
);

    localparam int H = N / 2;

    generate
        if ((N % 2) != 0 || N < 4) begin : g_bad_n
            $error("obs_split_feeder: N must be even and >= 4");
        end
    endgenerate

    typedef enum logic {S_IDLE, S_ISSUE} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [1:0]     r_tag;
    logic [1:0]     w_tag_nxt;
    logic           w_load;
    logic [H-1:0]   w_ae;
    logic [H-1:0]   w_ao;
    logic [H-1:0]   w_be;
    logic [H-1:0]   w_bo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_tag   <= 2'd0;
            r_a     <= '0;
            r_b     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_tag   <= w_tag_nxt;
            if (w_load) begin
                r_a <= in_a;
                r_b <= in_b;
            end
        end
    end

    // A new pair is accepted either from IDLE or on the last-beat handshake, so
    // back-to-back operands run with no idle bubble.
    always_comb begin
        w_state_nxt = r_state;
        w_tag_nxt   = r_tag;
        w_load      = 1'b0;
        in_ready    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_load      = 1'b1;
                    w_tag_nxt   = 2'd0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                in_ready = (r_tag == 2'd3) && out_ready;
                if (out_ready) begin
                    if (r_tag != 2'd3) begin
                        w_tag_nxt = r_tag + 2'd1;
                    end else begin
                        w_tag_nxt = 2'd0;
                        if (in_valid) begin
                            w_load = 1'b1;
                        end else begin
                            w_state_nxt = S_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tag_nxt   = 2'd0;
            end
        endcase
    end

    always_comb begin
        w_ae = '0;
        w_ao = '0;
        w_be = '0;
        w_bo = '0;
        for (int i = 0; i < H; i++) begin
            w_ae[i] = r_a[2*i];
            w_ao[i] = r_a[2*i+1];
            w_be[i] = r_b[2*i];
            w_bo[i] = r_b[2*i+1];
        end
    end

    // Pure bit-select from the held operands; tag[1] picks the A half, tag[0] the B half.
    assign out_a     = r_tag[1] ? w_ao : w_ae;
    assign out_b     = r_tag[0] ? w_bo : w_be;
    assign out_tag   = r_tag;
    assign out_valid = (r_state == S_ISSUE);
    assign out_last  = out_valid && (r_tag == 2'd3);
    assign busy      = (r_state == S_ISSUE);

endmodule

// File: tb/tb_obs_split_feeder.sv
// Directed-vector and randomized bench for obs_split_feeder (N=12): checks beat ordering,
// stalls, back-to-back capture, reset and the recombined 23-bit carry-less product.
module tb_obs_split_feeder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] in_a = '0;
    logic [11:0] in_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_a;
    logic [5:0]  out_b;
    logic [1:0]  out_tag;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int errors = 0;

    obs_split_feeder #(.N(12)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_a(out_a), .out_b(out_b), .out_tag(out_tag), .out_last(out_last),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [11:0] ia;
        logic [11:0] ib;
        logic        ordy;
        logic        ev;
        logic [5:0]  ea;
        logic [5:0]  eb;
        logic [1:0]  et;
        logic        el;
        logic        eir;
        logic        ebusy;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] clmul6(input logic [5:0] a, input logic [5:0] b);
        logic [10:0] r = '0;
        for (int i = 0; i < 6; i++)
            if (b[i]) r ^= (11'(a) << i);
        return r;
    endfunction

    function automatic logic [22:0] clmul12(input logic [11:0] a, input logic [11:0] b);
        logic [22:0] r = '0;
        for (int i = 0; i < 12; i++)
            if (b[i]) r ^= (23'(a) << i);
        return r;
    endfunction

    function automatic logic [22:0] spread(input logic [10:0] p);
        logic [22:0] r = '0;
        for (int i = 0; i < 11; i++)
            r[2*i] = p[i];
        return r;
    endfunction

    initial begin
        logic [11:0] q_a[$];
        logic [11:0] q_b[$];
        logic [10:0] p[4];
        logic [1:0]  exp_tag;
        logic [11:0] pa, pb;
        logic [22:0] got;
        int cyc, sent, done;
        bit need_new;

        //           iv    ia       ib       rdy   ev    ea     eb     et    el    eir   busy
        vecs[0]  = '{1'b1, 12'hA5C, 12'h555, 1'b1, 1'b0, 6'h00, 6'h00, 2'd0, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 6'h0E, 6'h3F, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[2]  = '{1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 6'h0E, 6'h00, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 6'h32, 6'h3F, 2'd2, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{1'b1, 12'hFFF, 12'h001, 1'b1, 1'b1, 6'h32, 6'h00, 2'd3, 1'b1, 1'b1, 1'b1};
        vecs[5]  = '{1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 6'h3F, 6'h01, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 12'h123, 12'h456, 1'b0, 1'b1, 6'h3F, 6'h00, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 12'h123, 12'h456, 1'b0, 1'b1, 6'h3F, 6'h00, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 12'h123, 12'h456, 1'b0, 1'b1, 6'h3F, 6'h00, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 12'h123, 12'h456, 1'b0, 1'b1, 6'h3F, 6'h00, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{1'b1, 12'h123, 12'h456, 1'b0, 1'b1, 6'h3F, 6'h00, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 6'h3F, 6'h00, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 6'h3F, 6'h01, 2'd2, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 12'h000, 12'h000, 1'b1, 1'b1, 6'h3F, 6'h01, 2'd2, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 12'h000, 12'h000, 1'b0, 1'b1, 6'h3F, 6'h00, 2'd3, 1'b1, 1'b0, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_a",     32'(out_a),     32'd0);
        check("rst_out_b",     32'(out_b),     32'd0);
        check("rst_out_tag",   32'(out_tag),   32'd0);
        check("rst_out_last",  32'(out_last),  32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready",  32'(in_ready),  32'd1);
        @(negedge clk);

        // Directed table: split, back-to-back, stall with busy guard, in_ready gating
        for (int i = 0; i < 15; i++) begin
            in_valid  = vecs[i].iv;
            in_a      = vecs[i].ia;
            in_b      = vecs[i].ib;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("v%0d_out_tag", i),   32'(out_tag),   32'(vecs[i].et));
            check($sformatf("v%0d_out_last", i),  32'(out_last),  32'(vecs[i].el));
            check($sformatf("v%0d_in_ready", i),  32'(in_ready),  32'(vecs[i].eir));
            check($sformatf("v%0d_busy", i),      32'(busy),      32'(vecs[i].ebusy));
            if (vecs[i].ev) begin
                check($sformatf("v%0d_out_a", i), 32'(out_a), 32'(vecs[i].ea));
                check($sformatf("v%0d_out_b", i), 32'(out_b), 32'(vecs[i].eb));
            end
            @(posedge clk);
            @(negedge clk);
        end
        // Last-beat handshake with no new pair: back to IDLE
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("idle_out_valid", 32'(out_valid), 32'd0);
        check("idle_busy",      32'(busy),      32'd0);
        check("idle_in_ready",  32'(in_ready),  32'd1);

        // Reset in the middle of an operation at tag2
        in_valid = 1'b1; in_a = 12'hA5C; in_b = 12'h555; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("midrst_pre_tag", 32'(out_tag), 32'd2);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_tag",   32'(out_tag),   32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_busy",     32'(busy),     32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("midrst_no_beats", 32'(out_valid), 32'd0);
        end

        // Random pairs recombined through a reference sub-multiplier and overlap combiner
        cyc = 0; sent = 0; done = 0; exp_tag = 2'd0; need_new = 1'b1;
        while (done < 1000 && cyc < 40000) begin
            if (need_new && sent < 1000) begin
                in_a = 12'($urandom);
                in_b = 12'($urandom);
                need_new = 1'b0;
            end
            in_valid  = (sent < 1000);
            out_ready = ($urandom_range(3) != 0);
            #1;
            if (in_valid && in_ready) begin
                q_a.push_back(in_a);
                q_b.push_back(in_b);
                sent++;
                need_new = 1'b1;
            end
            if (out_valid && out_ready) begin
                check("rand_beat_tag", 32'(out_tag), 32'(exp_tag));
                p[out_tag] = clmul6(out_a, out_b);
                exp_tag = exp_tag + 2'd1;
                if (out_tag == 2'd3) begin
                    if (q_a.size() == 0) begin
                        check("rand_unexpected_last", 32'd1, 32'd0);
                    end else begin
                        pa = q_a.pop_front();
                        pb = q_b.pop_front();
                        got = spread(p[0]) ^ (spread(p[1]) << 1) ^ (spread(p[2]) << 1)
                            ^ (spread(p[3]) << 2);
                        check("rand_product", 32'(got), 32'(clmul12(pa, pb)));
                    end
                    done++;
                end
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        if (done < 1000) check("rand_timeout", 32'(done), 32'd1000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
